llsc_ctrl: RTL and testbench

LLSC_CTRL -- requirements
Module: llsc_ctrl

---
 rtl/llsc_ctrl_pkg.sv | 14 +
 rtl/llsc_ctrl_resv_timer.sv | 28 ++
 rtl/llsc_ctrl.sv | 118 +++++++++++
 tb/tb_llsc_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/llsc_ctrl_pkg.sv
// Shared definitions for the LL/SC reservation controller: state encoding and
// default reservation granularity / expiry.
package llsc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESV  = 2'd1,
    SC_WR = 2'd2
  } llsc_state_e;

  localparam int GRAN_DEF    = 2;
  localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/llsc_ctrl_resv_timer.sv
// Reservation age counter: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches TIMEOUT.
module resv_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted in the cycle whose increment would bring the age to TIMEOUT.
  assign expired = enable && !clear && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/llsc_ctrl.sv
// LL/SC reservation controller: tracks one word reservation, resolves SC
// success/failure and issues the conditional store on the memory bus.
module llsc_ctrl
  import llsc_ctrl_pkg::*;
#(
  parameter int GRAN    = GRAN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ll_valid,
  input  logic [31:0] ll_addr,
  input  logic        sc_valid,
  input  logic [31:0] sc_addr,
  input  logic [31:0] sc_data,
  input  logic        snoop_we,
  input  logic [31:0] snoop_addr,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        stall_req,
  output logic        sc_done,
  output logic        sc_result,
  output logic        llbit_o
);

  llsc_state_e      state;
  logic [31-GRAN:0] resv_addr;
  logic             flushed;
  logic             snoop_hit;
  logic             sc_hit;
  logic             ll_take;
  logic             timer_clear;
  logic             expired;
  logic             unused_lo;

  assign snoop_hit = snoop_we && (snoop_addr[31:GRAN] == resv_addr);
  assign sc_hit    = sc_addr[31:GRAN] == resv_addr;
  assign unused_lo = ^{ll_addr[GRAN-1:0], sc_addr[GRAN-1:0], snoop_addr[GRAN-1:0]};

  // A pending SC owns the MEM-stage slot, so it is resolved ahead of an LL.
  assign ll_take     = (state != SC_WR) && !flush && !sc_valid && ll_valid;
  assign timer_clear = ll_take || (state != RESV);

  resv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (state == RESV),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      resv_addr <= '0;
      flushed   <= 1'b0;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      stall_req <= 1'b0;
      sc_done   <= 1'b0;
      sc_result <= 1'b0;
      llbit_o   <= 1'b0;
    end else begin
      sc_done   <= 1'b0;
      sc_result <= 1'b0;
      case (state)
        IDLE, RESV: begin
          if (flush) begin
            state   <= IDLE;
            llbit_o <= 1'b0;
          end else if (sc_valid) begin
            if (state == RESV && sc_hit && !snoop_hit) begin
              state     <= SC_WR;
              bus_req   <= 1'b1;
              stall_req <= 1'b1;
              bus_addr  <= sc_addr;
              bus_data  <= sc_data;
              flushed   <= 1'b0;
            end else begin
              state   <= IDLE;
              llbit_o <= 1'b0;
              sc_done <= 1'b1;
            end
          end else if (ll_take) begin
            state     <= RESV;
            resv_addr <= ll_addr[31:GRAN];
            llbit_o   <= 1'b1;
          end else if (state == RESV && (snoop_hit || expired)) begin
            state   <= IDLE;
            llbit_o <= 1'b0;
          end
        end
        SC_WR: begin
          // The bus write always runs to completion; a flush only hides the result.
          if (bus_ack) begin
            state     <= IDLE;
            llbit_o   <= 1'b0;
            bus_req   <= 1'b0;
            stall_req <= 1'b0;
            sc_done   <= !(flushed || flush);
            sc_result <= !(flushed || flush);
          end else if (flush) begin
            flushed <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          llbit_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llsc_ctrl.sv
// Randomized and directed bench for llsc_ctrl against a reservation-level model.
module tb_llsc_ctrl;

  localparam int GRAN    = 2;
  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst, flush, ll_valid, sc_valid, snoop_we, bus_ack;
  logic [31:0] ll_addr, sc_addr, sc_data, snoop_addr;
  logic        bus_req, stall_req, sc_done, sc_result, llbit_o;
  logic [31:0] bus_addr, bus_data;

  int checks = 0;
  int errors = 0;

  // Reservation-level model state
  bit          m_resv, m_wr, m_cancel, m_done, m_res;
  logic [31:0] m_word, m_baddr, m_bdata;
  int          m_age;

  llsc_ctrl #(.GRAN(GRAN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ll_valid   (ll_valid),
    .ll_addr    (ll_addr),
    .sc_valid   (sc_valid),
    .sc_addr    (sc_addr),
    .sc_data    (sc_data),
    .snoop_we   (snoop_we),
    .snoop_addr (snoop_addr),
    .bus_ack    (bus_ack),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .stall_req  (stall_req),
    .sc_done    (sc_done),
    .sc_result  (sc_result),
    .llbit_o    (llbit_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a >> GRAN;
  endfunction

  task automatic model_step();
    bit ok;
    m_done = 0;
    m_res  = 0;
    if (rst) begin
      m_resv = 0; m_wr = 0; m_cancel = 0; m_age = 0;
    end else if (m_wr) begin
      if (bus_ack) begin
        m_wr   = 0;
        m_resv = 0;
        m_done = !(m_cancel || flush);
        m_res  = m_done;
      end else if (flush) begin
        m_cancel = 1;
      end
    end else if (flush) begin
      m_resv = 0;
    end else if (sc_valid) begin
      ok = m_resv && word(sc_addr) == m_word && !(snoop_we && word(snoop_addr) == m_word);
      if (ok) begin
        m_wr = 1; m_cancel = 0; m_baddr = sc_addr; m_bdata = sc_data;
      end else begin
        m_resv = 0;
        m_done = 1;
      end
    end else if (ll_valid) begin
      m_resv = 1; m_word = word(ll_addr); m_age = 0;
    end else if (m_resv) begin
      m_age++;
      if ((snoop_we && word(snoop_addr) == m_word) || m_age == TIMEOUT) m_resv = 0;
    end
  endtask

  task automatic check_outputs();
    check("llbit_o", 32'(llbit_o), 32'(m_resv || m_wr));
    check("bus_req", 32'(bus_req), 32'(m_wr));
    check("stall_req", 32'(stall_req), 32'(m_wr));
    check("sc_done", 32'(sc_done), 32'(m_done));
    if (m_done) check("sc_result", 32'(sc_result), 32'(m_res));
    if (m_wr) begin
      check("bus_addr", bus_addr, m_baddr);
      check("bus_data", bus_data, m_bdata);
    end
  endtask

  task automatic cyc(input bit l, input logic [31:0] la, input bit s, input logic [31:0] sa,
                     input logic [31:0] sd, input bit sn, input logic [31:0] sna,
                     input bit ak, input bit fl);
    ll_valid = l; ll_addr = la; sc_valid = s; sc_addr = sa; sc_data = sd;
    snoop_we = sn; snoop_addr = sna; bus_ack = ak; flush = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit ak = 0, input bit fl = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, ak, fl);
  endtask

  task automatic do_rst();
    rst = 1;
    idle();
    rst = 0;
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_data", bus_data, 32'h0);
    check("rst_sc_result", 32'(sc_result), 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h100;
      1: return 32'h102;
      2: return 32'h104;
      3: return 32'h200;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 0;
    @(negedge clk);
    do_rst();

    // Successful SC: bus_req held three cycles, ack on the third
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 1, 32'h100, 32'hCAFE_F00D, 0, 0, 0, 0);
    idle();
    idle();
    idle(1);
    check("d1_done", 32'(sc_done), 32'h1);
    check("d1_result", 32'(sc_result), 32'h1);
    check("d1_llbit", 32'(llbit_o), 32'h0);

    // Snoop to the same word kills the reservation
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h102, 0, 0);
    cyc(0, 0, 1, 32'h100, 32'h1234, 0, 0, 0, 0);
    check("d2_done", 32'(sc_done), 32'h1);
    check("d2_result", 32'(sc_result), 32'h0);
    check("d2_bus_req", 32'(bus_req), 32'h0);

    // Expiry after TIMEOUT cycles
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle();
    check("d3_llbit_last", 32'(llbit_o), 32'h1);
    idle();
    check("d3_llbit_expired", 32'(llbit_o), 32'h0);
    cyc(0, 0, 1, 32'h100, 32'h55, 0, 0, 0, 0);
    check("d3_result", 32'(sc_done && !sc_result), 32'h1);

    // Address mismatch
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h104, 32'h66, 0, 0, 0, 0);
    check("d4_done", 32'(sc_done), 32'h1);
    check("d4_result", 32'(sc_result), 32'h0);
    check("d4_llbit", 32'(llbit_o), 32'h0);

    // LL wins against a same-cycle snoop of the old reservation
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h200, 0, 0, 0, 1, 32'h100, 0, 0);
    check("d5_llbit", 32'(llbit_o), 32'h1);

    // Flush during the bus write: completes without sc_done
    cyc(0, 0, 1, 32'h200, 32'h77, 0, 0, 0, 0);
    idle(0, 1);
    idle();
    idle(1);
    check("d6_done", 32'(sc_done), 32'h0);
    check("d6_llbit", 32'(llbit_o), 32'h0);
    check("d6_bus_req", 32'(bus_req), 32'h0);

    // Reset in the middle of a bus write
    cyc(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h300, 32'h88, 0, 0, 0, 0);
    check("d7_bus_req_pre", 32'(bus_req), 32'h1);
    do_rst();
    check("d7_bus_req", 32'(bus_req), 32'h0);
    check("d7_stall", 32'(stall_req), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) begin
        do_rst();
      end else begin
        cyc(op < 3, pick(), op >= 3 && op < 5, pick(), $urandom,
            $urandom_range(0, 3) == 0, pick(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
